// File: rtl/line_draw_engine.sv
// line_draw_engine
//   Self-sequenced Bresenham line engine covering all eight octants. One
//   endpoint pair is accepted per start; pixels leave one per plot/plot_ready
//   handshake toward the VGA write port.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             line request (IDLE only) / cancel current line
//   x0, y0, x1, y1           endpoints, latched with start
//   colour_in                line colour, latched with start
//   plot_ready               VGA side accepts the pixel this cycle
//   x_out, y_out, colour_out current pixel
//   plot                     pixel valid
//   busy                     engine owns a line (any state but IDLE)
//   done                     one-cycle pulse after the last pixel transfers
module line_draw_engine #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                plot_ready,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  // Common internal coordinate width; the error term needs two extra bits
  // (sign plus headroom for err+dy and err-dx at full extent).
  localparam int W  = (X_W > Y_W) ? X_W : Y_W;
  localparam int EW = W + 2;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_DRAW, S_DONE} state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pt_t;

  state_t state, state_nxt;

  // Endpoints: raw after IDLE, octant-normalised after SETUP.
  pt_t                  pa, pb;
  logic [COLOUR_W-1:0]  colour_q;
  logic                 steep;
  logic [W-1:0]         dx, dy;
  logic                 ystep_up;
  logic signed [EW-1:0] err;
  logic [W-1:0]         x, y;

  // ---------------------------------------------------------------------
  // SETUP: decide steepness, mirror across the diagonal if steep, then
  // order the endpoints so the walk always runs in +x.
  // ---------------------------------------------------------------------
  logic [W-1:0] adx, ady;
  logic         steep_c, swap_c;
  pt_t          pa_m, pb_m, pa_s, pb_s;

  always_comb begin
    adx     = (pb.x >= pa.x) ? pb.x - pa.x : pa.x - pb.x;
    ady     = (pb.y >= pa.y) ? pb.y - pa.y : pa.y - pb.y;
    steep_c = ady > adx;                       // a tie stays shallow
    pa_m    = steep_c ? '{x: pa.y, y: pa.x} : pa;
    pb_m    = steep_c ? '{x: pb.y, y: pb.x} : pb;
    swap_c  = pa_m.x > pb_m.x;
    pa_s    = swap_c ? pb_m : pa_m;
    pb_s    = swap_c ? pa_m : pb_m;
  end

  // ---------------------------------------------------------------------
  // LOAD / DRAW arithmetic
  // ---------------------------------------------------------------------
  logic [W-1:0]         dx_c, dy_c;
  logic signed [EW-1:0] dx_s, dy_s, e_c;
  logic                 e_pos, last_px, xfer;

  always_comb begin
    dx_c    = pb.x - pa.x;
    dy_c    = (pb.y >= pa.y) ? pb.y - pa.y : pa.y - pb.y;
    dx_s    = $signed({2'b00, dx});
    dy_s    = $signed({2'b00, dy});
    e_c     = err + dy_s;
    e_pos   = !e_c[EW-1] && (e_c != '0);
    last_px = (x == pb.x);
    xfer    = (state == S_DRAW) && plot_ready && !abort;
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    plot      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_SETUP;
      end
      S_SETUP: state_nxt = abort ? S_IDLE : S_LOAD;
      S_LOAD:  state_nxt = abort ? S_IDLE : S_DRAW;
      S_DRAW: begin
        plot = 1'b1;
        // abort wins over a transfer landing in the same cycle
        if (abort)                     state_nxt = S_IDLE;
        else if (plot_ready && last_px) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa       <= '0;
      pb       <= '0;
      colour_q <= '0;
      steep    <= 1'b0;
      dx       <= '0;
      dy       <= '0;
      ystep_up <= 1'b0;
      err      <= '0;
      x        <= '0;
      y        <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pa       <= '{x: W'(x0), y: W'(y0)};
          pb       <= '{x: W'(x1), y: W'(y1)};
          colour_q <= colour_in;
        end
        S_SETUP: begin
          steep <= steep_c;
          pa    <= pa_s;
          pb    <= pb_s;
        end
        S_LOAD: begin
          dx       <= dx_c;
          dy       <= dy_c;
          ystep_up <= pa.y < pb.y;
          err      <= -$signed({2'b00, dx_c >> 1});
          x        <= pa.x;
          y        <= pa.y;
        end
        S_DRAW: if (xfer && !last_px) begin
          if (e_pos) begin
            y   <= ystep_up ? y + W'(1) : y - W'(1);
            err <= e_c - dx_s;
          end else begin
            err <= e_c;
          end
          x <= x + W'(1);
        end
        default: ;
      endcase
    end
  end

  // Pixel coordinates are un-mirrored on the way out; x/y only move on a
  // transfer so a stalled pixel stays put.
  assign x_out      = X_W'(steep ? y : x);
  assign y_out      = Y_W'(steep ? x : y);
  assign colour_out = colour_q;

endmodule

// File: tb/tb_line_draw_engine.sv
module tb_line_draw_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, plot_ready;
  logic [8:0] x0, x1, x_out;
  logic [7:0] y0, y1, y_out;
  logic [2:0] colour_in, colour_out;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  line_draw_engine #(.X_W(9), .Y_W(8), .COLOUR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
    .plot_ready(plot_ready), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
  );

  typedef struct {
    int x0, y0, x1, y1, col, n;
    int px[8];
    int py[8];
  } vec_t;

  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
    x0 = 9'(ax0); y0 = 8'(ay0); x1 = 9'(ax1); y1 = 8'(ay1);
    colour_in = 3'(col);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full ready-high line: latency, pixel stream, done pulse, busy drop.
  task automatic run_line(input vec_t v, input string tag);
    plot_ready = 1'b1;
    issue(v.x0, v.y0, v.x1, v.y1, v.col);
    chk({tag, " setup busy"}, busy, 1);
    chk({tag, " setup plot"}, plot, 0);
    tick();
    chk({tag, " load plot"}, plot, 0);
    tick();
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("%s px%0d plot", tag, i), plot, 1);
      chk($sformatf("%s px%0d x", tag, i), x_out, v.px[i]);
      chk($sformatf("%s px%0d y", tag, i), y_out, v.py[i]);
      chk($sformatf("%s px%0d colour", tag, i), colour_out, v.col);
      tick();
    end
    chk({tag, " done pulse"}, done, 1);
    chk({tag, " done plot"}, plot, 0);
    tick();
    chk({tag, " done cleared"}, done, 0);
    chk({tag, " busy cleared"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_x, bad_mono, bad_plot, first_y, last_y, prev_y;

    vecs[0] = '{0, 0, 4, 0, 5, 5, '{0, 1, 2, 3, 4, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{2, 5, 0, 0, 3, 6, '{0, 0, 1, 1, 2, 2, 0, 0}, '{0, 1, 2, 3, 4, 5, 0, 0}};
    vecs[2] = '{7, 7, 7, 7, 6, 1, '{7, 0, 0, 0, 0, 0, 0, 0}, '{7, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{5, 5, 6, 5, 1, 2, '{5, 6, 0, 0, 0, 0, 0, 0}, '{5, 5, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{4, 0, 0, 2, 2, 5, '{0, 1, 2, 3, 4, 0, 0, 0}, '{2, 2, 1, 1, 0, 0, 0, 0}};
    vecs[5] = '{0, 0, 3, 3, 4, 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0}};
    vecs[6] = '{3, 1, 3, 4, 7, 4, '{3, 3, 3, 3, 0, 0, 0, 0}, '{1, 2, 3, 4, 0, 0, 0, 0}};
    vecs[7] = '{0, 4, 1, 0, 3, 5, '{1, 1, 1, 0, 0, 0, 0, 0}, '{0, 1, 2, 3, 4, 0, 0, 0}};

    rst = 1'b1; start = 1'b0; abort = 1'b0; plot_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0;
    #3;
    chk("reset plot", plot, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset x_out", x_out, 0);
    chk("reset y_out", y_out, 0);
    chk("reset colour", colour_out, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_line(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: second pixel stalled for 3 cycles, held 4 cycles total.
    plot_ready = 1'b1;
    issue(0, 0, 3, 3, 2);
    tick();
    tick();
    chk("bp px0 x", x_out, 0);
    chk("bp px0 y", y_out, 0);
    tick();
    plot_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) plot_ready = 1'b1;
      chk($sformatf("bp hold%0d plot", c), plot, 1);
      chk($sformatf("bp hold%0d x", c), x_out, 1);
      chk($sformatf("bp hold%0d y", c), y_out, 1);
      if (c < 3) begin
        #4;
        chk($sformatf("bp hold%0d done", c), done, 0);
        @(posedge clk);
        #1;
      end
    end
    tick();
    chk("bp px2 x", x_out, 2);
    chk("bp px2 y", y_out, 2);
    tick();
    chk("bp px3 x", x_out, 3);
    chk("bp px3 y", y_out, 3);
    tick();
    chk("bp done", done, 1);
    tick();
    chk("bp busy", busy, 0);

    // Abort after 10 transfers, with an ignored start pulse mid-line.
    issue(0, 0, 100, 0, 2);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("abort px%0d x", i), x_out, i);
      if (i == 5) begin
        start = 1'b1; x0 = 9'd50; y0 = 8'd9; colour_in = 3'd6;
      end
      tick();
      start = 1'b0;
    end
    chk("abort px10 x", x_out, 10);
    chk("abort px10 colour", colour_out, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort plot", plot, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    tick();
    chk("abort no done", done, 0);
    chk("abort stays idle", busy, 0);

    // Abort while in SETUP.
    issue(1, 1, 9, 9, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("setup abort busy", busy, 0);
    chk("setup abort plot", plot, 0);
    tick();
    chk("setup abort done", done, 0);

    run_line(vecs[3], "restart");

    // Full extent, reversed.
    issue(319, 239, 0, 0, 7);
    tick();
    tick();
    bad_x = 0; bad_mono = 0; bad_plot = 0; first_y = -1; last_y = -1; prev_y = 0;
    for (int i = 0; i < 320; i++) begin
      if (plot !== 1'b1) bad_plot++;
      if (int'(x_out) != i) bad_x++;
      if (i == 0) first_y = y_out;
      else if (int'(y_out) < prev_y || int'(y_out) > prev_y + 1) bad_mono++;
      prev_y = y_out;
      last_y = y_out;
      tick();
    end
    chk("full plot gaps", bad_plot, 0);
    chk("full x sequence", bad_x, 0);
    chk("full y monotonic", bad_mono, 0);
    chk("full first y", first_y, 0);
    chk("full last y", last_y, 239);
    chk("full done", done, 1);
    tick();

    // Async reset mid-line.
    issue(319, 239, 0, 0, 7);
    tick();
    tick();
    for (int i = 0; i < 50; i++) tick();
    chk("rst pre x", x_out, 50);
    chk("rst pre colour", colour_out, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async plot", plot, 0);
    chk("rst async busy", busy, 0);
    chk("rst async x_out", x_out, 0);
    chk("rst async y_out", y_out, 0);
    chk("rst async colour", colour_out, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst after busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
